// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: computes a - b LSB first through one full-subtractor
// cell and a registered borrow. Define SERIAL_SUBTRACTOR_OVF_EN for two's-complement overflow.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int             CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic [CW-1:0]    cnt;
    logic             brw;
    logic             d;
    logic             brw_next;
    logic             accept;
    logic             last;

    // The one-bit ALU: a full subtractor on the current LSBs and the stored borrow.
    assign d        = sa[0] ^ sb[0] ^ brw;
    assign brw_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & brw);

    assign accept = start && ((state == IDLE) || (state == DONE));
    assign last   = (state == RUN) && (cnt == LAST_BIT);

    // NOTE: every signal written in an always_comb gets a default first, so no path infers a latch.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == LAST_BIT) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = start ? RUN : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: the operand/result shift registers are reset too, keeping diff defined from reset onward.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa   <= '0;
            sb   <= '0;
            res  <= '0;
            cnt  <= '0;
            brw  <= 1'b0;
            diff <= '0;
            bout <= 1'b0;
        end else if (accept) begin
            sa  <= a;
            sb  <= b;
            cnt <= '0;
            brw <= 1'b0;
        end else if (state == RUN) begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            res <= {d, res[WIDTH-1:1]};
            brw <= brw_next;
            cnt <= cnt + CW'(1);
            if (last) begin
                diff <= {d, res[WIDTH-1:1]};
                bout <= brw_next;
            end
        end
    end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic ovf_q;

    // On the last RUN cycle sa[0]/sb[0] are the captured operand MSBs and d is the result MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (last) begin
            ovf_q <= (sa[0] != sb[0]) && (d != sa[0]);
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: an arithmetic reference model compared every
// cycle, plus directed literal cases, reset abort, back-to-back and randomized traffic.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain arithmetic, returns {ovf, bout, diff}.
    function automatic logic [W+1:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y);
        int           r;
        logic         o;
        logic         bo;
        logic [W-1:0] dd;
        r  = int'($signed(x)) - int'($signed(y));
        dd = x - y;
        bo = (x < y);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        o  = (r < -(1 << (W - 1))) || (r > (1 << (W - 1)) - 1);
`else
        o  = 1'b0;
`endif
        return {o, bo, dd};
    endfunction

    // Behavioural model: an accepted request is busy for W cycles, then done for one.
    logic         m_busy;
    logic         m_done;
    int           m_left;
    logic [W+1:0] m_pend;
    logic [W-1:0] m_diff;
    logic         m_bout;
    logic         m_ovf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_left <= 0;
            m_pend <= '0;
            m_diff <= '0;
            m_bout <= 1'b0;
            m_ovf  <= 1'b0;
        end else if (m_busy) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                {m_ovf, m_bout, m_diff} <= m_pend;
            end
        end else begin
            m_done <= 1'b0;
            if (start) begin
                m_busy <= 1'b1;
                m_left <= W;
                m_pend <= ref_sub(a, b);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            check("cyc_busy", busy, m_busy);
            check("cyc_done", done, m_done);
            check("cyc_diff", diff, m_diff);
            check("cyc_bout", bout, m_bout);
            check("cyc_ovf",  ovf,  m_ovf);
        end
    end

    task automatic wait_done(output int n_busy, output bit seen);
        n_busy = 0;
        seen   = 0;
        for (int i = 0; i < 4 * W && !seen; i++) begin
            if (done) begin
                seen = 1;
            end else begin
                if (busy) n_busy++;
                @(negedge clk);
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic [W-1:0] ed, input logic eb, input logic eo);
        int n_busy;
        bit seen;
        @(negedge clk);
        a = ta; b = tb_v; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = W'($urandom); b = W'($urandom);
        wait_done(n_busy, seen);
        check({tag, "_seen"},  32'(seen), 32'd1);
        check({tag, "_nbusy"}, n_busy, W);
        check({tag, "_diff"},  diff, ed);
        check({tag, "_bout"},  bout, eb);
        check({tag, "_ovf"},   ovf,  eo);
        check({tag, "_mdiff"}, m_diff, ed);
        check({tag, "_mbout"}, m_bout, eb);
        @(negedge clk);
        check({tag, "_pulse"}, done, 1'b0);
    endtask

    initial begin
        int  n_busy;
        bit  seen;
        int  pulses;
        int  last_cyc;
        logic exp_ovf_80;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
        exp_ovf_80 = 1'b1;
`else
        exp_ovf_80 = 1'b0;
`endif
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        #12;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_diff", diff, '0);
        check("rst_bout", bout, 1'b0);
        check("rst_ovf",  ovf,  1'b0);
        @(negedge clk);
        rst_n  = 1'b1;
        cmp_en = 1;

        run_op("sub_05_03", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
        run_op("sub_03_05", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
        run_op("sub_80_01", 8'h80, 8'h01, 8'h7F, 1'b0, exp_ovf_80);

        // Start while busy must be ignored.
        @(negedge clk);
        a = 8'hFF; b = 8'h00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        a = 8'h00; b = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n_busy, seen);
        check("ign_seen", 32'(seen), 32'd1);
        check("ign_diff", diff, 8'hFF);
        check("ign_bout", bout, 1'b0);
        pulses = 0;
        repeat (2 * W) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("ign_extra_pulses", pulses, 0);

        // Reset mid-RUN: outputs clear immediately, no done afterwards.
        @(negedge clk);
        a = 8'h55; b = 8'h22; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_diff", diff, '0);
        check("abort_bout", bout, 1'b0);
        check("abort_ovf",  ovf,  1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (2 * W + 4) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("abort_no_done", pulses, 0);

        // start held high: one result every W+1 cycles.
        @(negedge clk);
        a = 8'h10; b = 8'h01; start = 1'b1;
        pulses   = 0;
        last_cyc = -1;
        for (int c = 0; c < 5 * (W + 1); c++) begin
            @(negedge clk);
            if (done) begin
                check("held_diff", diff, 8'h0F);
                check("held_bout", bout, 1'b0);
                if (last_cyc >= 0) check("held_period", c - last_cyc, W + 1);
                last_cyc = c;
                pulses++;
            end
        end
        check("held_pulses_ge4", 32'(pulses >= 4), 32'd1);
        start = 1'b0;
        repeat (2 * W) @(negedge clk);

        // Randomized traffic, including starts while busy.
        pulses = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (done) pulses++;
            start = ($urandom_range(0, 2) == 0);
            a = W'($urandom);
            b = W'($urandom);
        end
        start = 1'b0;
        check("rand_activity", 32'(pulses > 100), 32'd1);
        repeat (2 * W) @(negedge clk);

        cmp_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
